// File: rtl/svc_stream_serializer_if.sv
// Stream handshake bundle for svc_stream_serializer.
// Upstream side:   i_valid, i_data (wide word), o_ready.
// Downstream side: o_valid, o_data (one beat), o_last, i_ready.
// Signal names are seen from the serializer: i_* flow into it, o_* flow out.
//   slave  - the serializer
//   master - whatever drives the upstream word and consumes the beats
interface svc_stream_serializer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BEATS      = 4
);
  logic                          i_valid;
  logic                          o_ready;
  logic [BEATS*DATA_WIDTH-1:0]   i_data;
  logic                          o_valid;
  logic                          i_ready;
  logic [DATA_WIDTH-1:0]         o_data;
  logic                          o_last;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_last
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_last
  );
endinterface

// File: rtl/svc_stream_serializer.sv
// Wide-to-narrow stream serializer: accepts one BEATS*DATA_WIDTH word and emits
// it as BEATS beats of DATA_WIDTH bits, LSB slice first (or MSB slice first when
// OPT_MSB_FIRST=1). The next word may be accepted in the same cycle the last
// beat leaves, so back-to-back words stream with no bubble.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - slave side of svc_stream_serializer_if (upstream word in, beats out)
module svc_stream_serializer #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned BEATS         = 4,
  parameter bit          OPT_MSB_FIRST = 1'b0
) (
  input logic                    clk,
  input logic                    rst,
  svc_stream_serializer_if.slave bus
);

  localparam int unsigned CntWidth = ($clog2(BEATS) > 1) ? $clog2(BEATS) : 1;
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(BEATS - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e                             state_q, state_d;
  logic [CntWidth-1:0]                cnt_q, cnt_d;
  logic [BEATS-1:0][DATA_WIDTH-1:0]   data_q;
  logic                               load;
  logic                               busy;
  logic                               is_last;
  logic                               ready;
  logic                               in_xfer;
  logic                               out_xfer;
  logic [CntWidth-1:0]                sel;

  assign busy     = (state_q == StBusy);
  assign is_last  = (cnt_q == LastCnt);
  // Only combinational input-to-output path: the last beat leaving frees the slot.
  assign ready    = !busy || (bus.i_ready && is_last);
  assign in_xfer  = bus.i_valid && ready;
  assign out_xfer = busy && bus.i_ready;

  assign sel = OPT_MSB_FIRST ? (LastCnt - cnt_q) : cnt_q;

  assign bus.o_ready = ready;
  assign bus.o_valid = busy;
  assign bus.o_last  = busy && is_last;
  assign bus.o_data  = data_q[sel];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_xfer) begin
          state_d = StBusy;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      StBusy: begin
        if (out_xfer) begin
          if (is_last) begin
            // in_xfer can only fire here while busy; reload keeps the stream gapless.
            if (in_xfer) begin
              cnt_d = '0;
              load  = 1'b1;
            end else begin
              state_d = StIdle;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + CntWidth'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        data_q <= bus.i_data;
      end
    end
  end

endmodule

// File: tb/tb_svc_stream_serializer.sv
// Bench for svc_stream_serializer: an LSB-first and an MSB-first instance see
// identical stimulus. A queue-of-beats reference model checks every cycle; a
// vector table and short directed sequences pin the named corner cases.
module tb_svc_stream_serializer;

  localparam int unsigned DW = 8;
  localparam int unsigned NB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready = 1'b0;
  logic [NB*DW-1:0] in_data = '0;

  always #5 clk = ~clk;

  svc_stream_serializer_if #(.DATA_WIDTH(DW), .BEATS(NB)) bus_lsb ();
  svc_stream_serializer_if #(.DATA_WIDTH(DW), .BEATS(NB)) bus_msb ();

  assign bus_lsb.i_valid = in_valid;
  assign bus_lsb.i_ready = in_ready;
  assign bus_lsb.i_data  = in_data;
  assign bus_msb.i_valid = in_valid;
  assign bus_msb.i_ready = in_ready;
  assign bus_msb.i_data  = in_data;

  svc_stream_serializer #(.DATA_WIDTH(DW), .BEATS(NB), .OPT_MSB_FIRST(1'b0)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_lsb)
  );

  svc_stream_serializer #(.DATA_WIDTH(DW), .BEATS(NB), .OPT_MSB_FIRST(1'b1)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus_msb)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk1(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk8(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: the beats still owed downstream, in emission order.
  logic [DW-1:0] q_lsb[$];
  logic [DW-1:0] q_msb[$];

  function automatic logic model_ready();
    return (q_lsb.size() == 0) || (in_ready && q_lsb.size() == 1);
  endfunction

  function automatic void model_check();
    chk1("lsb_valid", bus_lsb.o_valid, q_lsb.size() != 0);
    chk1("msb_valid", bus_msb.o_valid, q_msb.size() != 0);
    chk1("lsb_ready", bus_lsb.o_ready, model_ready());
    chk1("msb_ready", bus_msb.o_ready, model_ready());
    chk1("lsb_last", bus_lsb.o_last, q_lsb.size() == 1);
    chk1("msb_last", bus_msb.o_last, q_msb.size() == 1);
    if (q_lsb.size() != 0) chk8("lsb_data", bus_lsb.o_data, q_lsb[0]);
    if (q_msb.size() != 0) chk8("msb_data", bus_msb.o_data, q_msb[0]);
  endfunction

  function automatic void model_update();
    logic accept;
    if (rst) begin
      q_lsb.delete();
      q_msb.delete();
      return;
    end
    accept = in_valid && model_ready();
    if (q_lsb.size() != 0 && in_ready) begin
      void'(q_lsb.pop_front());
      void'(q_msb.pop_front());
    end
    if (accept) begin
      for (int b = 0; b < NB; b++) begin
        q_lsb.push_back(in_data[b*DW +: DW]);
        q_msb.push_back(in_data[(NB-1-b)*DW +: DW]);
      end
    end
  endfunction

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // flags = {i_valid, i_ready, exp_valid, exp_ready, exp_last}
  typedef struct {
    logic [4:0]       flags;
    logic [NB*DW-1:0] data;
    logic [DW-1:0]    ed_lsb;
    logic [DW-1:0]    ed_msb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [4:0] f, logic [NB*DW-1:0] d, logic [DW-1:0] el,
                              logic [DW-1:0] em);
    vec_t v;
    v.flags  = f;
    v.data   = d;
    v.ed_lsb = el;
    v.ed_msb = em;
    return v;
  endfunction

  initial begin
    // basic flow
    tbl.push_back(mk(5'b11010, 32'hDDCCBBAA, 8'h00, 8'h00));
    tbl.push_back(mk(5'b01100, 32'h0, 8'hAA, 8'hDD));
    tbl.push_back(mk(5'b01100, 32'h0, 8'hBB, 8'hCC));
    tbl.push_back(mk(5'b01100, 32'h0, 8'hCC, 8'hBB));
    tbl.push_back(mk(5'b01111, 32'h0, 8'hDD, 8'hAA));
    tbl.push_back(mk(5'b01010, 32'h0, 8'h00, 8'h00));
    // backpressure on the first beat
    tbl.push_back(mk(5'b10010, 32'hDDCCBBAA, 8'h00, 8'h00));
    tbl.push_back(mk(5'b00100, 32'h0, 8'hAA, 8'hDD));
    tbl.push_back(mk(5'b00100, 32'h0, 8'hAA, 8'hDD));
    tbl.push_back(mk(5'b00100, 32'h0, 8'hAA, 8'hDD));
    tbl.push_back(mk(5'b01100, 32'h0, 8'hAA, 8'hDD));
    tbl.push_back(mk(5'b01100, 32'h0, 8'hBB, 8'hCC));
    tbl.push_back(mk(5'b01100, 32'h0, 8'hCC, 8'hBB));
    tbl.push_back(mk(5'b01111, 32'h0, 8'hDD, 8'hAA));
    tbl.push_back(mk(5'b01010, 32'h0, 8'h00, 8'h00));
    // back-to-back words
    tbl.push_back(mk(5'b11010, 32'h03020100, 8'h00, 8'h00));
    tbl.push_back(mk(5'b11100, 32'h07060504, 8'h00, 8'h03));
    tbl.push_back(mk(5'b11100, 32'h07060504, 8'h01, 8'h02));
    tbl.push_back(mk(5'b11100, 32'h07060504, 8'h02, 8'h01));
    tbl.push_back(mk(5'b11111, 32'h07060504, 8'h03, 8'h00));
    tbl.push_back(mk(5'b01100, 32'h0, 8'h04, 8'h07));
    tbl.push_back(mk(5'b01100, 32'h0, 8'h05, 8'h06));
    tbl.push_back(mk(5'b01100, 32'h0, 8'h06, 8'h05));
    tbl.push_back(mk(5'b01111, 32'h0, 8'h07, 8'h04));
    tbl.push_back(mk(5'b01010, 32'h0, 8'h00, 8'h00));
    // last-beat stall with a word waiting, then a gapless reload
    tbl.push_back(mk(5'b11010, 32'hDDCCBBAA, 8'h00, 8'h00));
    tbl.push_back(mk(5'b01100, 32'h0, 8'hAA, 8'hDD));
    tbl.push_back(mk(5'b01100, 32'h0, 8'hBB, 8'hCC));
    tbl.push_back(mk(5'b01100, 32'h0, 8'hCC, 8'hBB));
    tbl.push_back(mk(5'b10101, 32'h11223344, 8'hDD, 8'hAA));
    tbl.push_back(mk(5'b10101, 32'h11223344, 8'hDD, 8'hAA));
    tbl.push_back(mk(5'b11111, 32'h11223344, 8'hDD, 8'hAA));
    tbl.push_back(mk(5'b01100, 32'h0, 8'h44, 8'h11));
    tbl.push_back(mk(5'b01100, 32'h0, 8'h33, 8'h22));
    tbl.push_back(mk(5'b01100, 32'h0, 8'h22, 8'h33));
    tbl.push_back(mk(5'b01111, 32'h0, 8'h11, 8'h44));
    tbl.push_back(mk(5'b01010, 32'h0, 8'h00, 8'h00));

    // reset and post-reset state
    #1;
    rst = 1'b1;
    in_ready = 1'b1;
    advance();
    advance();
    rst = 1'b0;
    sample();
    chk1("rst_valid", bus_lsb.o_valid, 1'b0);
    chk1("rst_last", bus_lsb.o_last, 1'b0);
    chk1("rst_ready", bus_lsb.o_ready, 1'b1);
    chk8("rst_data_lsb", bus_lsb.o_data, 8'h00);
    chk8("rst_data_msb", bus_msb.o_data, 8'h00);
    advance();

    foreach (tbl[i]) begin
      in_valid = tbl[i].flags[4];
      in_ready = tbl[i].flags[3];
      in_data  = tbl[i].data;
      sample();
      chk1("row_valid", bus_lsb.o_valid, tbl[i].flags[2]);
      chk1("row_ready", bus_lsb.o_ready, tbl[i].flags[1]);
      chk1("row_last", bus_lsb.o_last, tbl[i].flags[0]);
      chk1("row_valid_msb", bus_msb.o_valid, tbl[i].flags[2]);
      chk1("row_last_msb", bus_msb.o_last, tbl[i].flags[0]);
      if (tbl[i].flags[2]) begin
        chk8("row_data_lsb", bus_lsb.o_data, tbl[i].ed_lsb);
        chk8("row_data_msb", bus_msb.o_data, tbl[i].ed_msb);
      end
      advance();
    end

    // reset mid-word: asserted while BB is on the output
    in_valid = 1'b1;
    in_ready = 1'b1;
    in_data  = 32'hDDCCBBAA;
    sample();
    advance();
    in_valid = 1'b0;
    in_data  = '0;
    sample();
    chk8("mid_aa", bus_lsb.o_data, 8'hAA);
    advance();
    rst = 1'b1;
    sample();
    chk8("mid_bb", bus_lsb.o_data, 8'hBB);
    advance();
    rst = 1'b0;
    sample();
    chk1("mid_rst_valid", bus_lsb.o_valid, 1'b0);
    chk1("mid_rst_last", bus_lsb.o_last, 1'b0);
    chk1("mid_rst_ready", bus_lsb.o_ready, 1'b1);
    advance();
    for (int k = 0; k < 5; k++) begin
      sample();
      chk1("mid_no_beat", bus_lsb.o_valid, 1'b0);
      advance();
    end

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(0, 99) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      in_ready = $urandom_range(0, 3) != 0;
      in_data  = $urandom;
      sample();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/svc_stream_serializer.md
SVC_STREAM_SERIALIZER -- requirements
Module: svc_stream_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of one output beat in bits.
REQ-002 SHALL have parameter BEATS, default 4: output beats per input word; legal range >= 2.
REQ-003 SHALL have parameter OPT_MSB_FIRST, default 0: 0 emits the least-significant slice first, 1 emits the most-significant slice first.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port i_valid, input, 1: an upstream wide word is present.
REQ-007 SHALL have port o_ready, output, 1: the block accepts the upstream word this cycle.
REQ-008 SHALL have port i_data, input, BEATS*DATA_WIDTH: the upstream wide word.
REQ-009 SHALL have port o_valid, output, 1: a downstream beat is present.
REQ-010 SHALL have port i_ready, input, 1: downstream accepts the beat this cycle.
REQ-011 SHALL have port o_data, output, DATA_WIDTH: the current beat.
REQ-012 SHALL have port o_last, output, 1: the current beat is the final beat of its word.

Function
REQ-013 SHALL hold internal state: the word register data_q (BEATS*DATA_WIDTH), the beat counter cnt (max(1,$clog2(BEATS)) bits) and the busy flag.
REQ-014 SHALL define an input transfer as i_valid && o_ready, and an output transfer as o_valid && i_ready.
REQ-015 SHALL drive o_valid = busy, registered with no combinational dependence on i_valid.
REQ-016 SHALL drive o_ready = !busy || (i_ready && cnt == BEATS-1), the only combinational input-to-output path.
REQ-017 SHALL, on an input transfer, load data_q <= i_data, cnt <= 0 and busy <= 1.
REQ-018 SHALL present the first beat of an accepted word on o_data in the cycle after the accept, giving one cycle of latency.
REQ-019 SHALL drive o_data = data_q[cnt*DATA_WIDTH +: DATA_WIDTH] when OPT_MSB_FIRST=0.
REQ-020 SHALL drive o_data = data_q[(BEATS-1-cnt)*DATA_WIDTH +: DATA_WIDTH] when OPT_MSB_FIRST=1.
REQ-021 SHALL drive o_last = busy && (cnt == BEATS-1).
REQ-022 SHALL, on an output transfer with cnt < BEATS-1, increment cnt by 1.
REQ-023 SHALL, on an output transfer with cnt == BEATS-1 and no input transfer in the same cycle, clear busy to 0 and cnt to 0.
REQ-024 SHALL, on an output transfer of the last beat together with an input transfer in the same cycle, reload per REQ-017 so beats stream back-to-back with no bubble.
REQ-025 SHALL, when o_valid=1 and i_ready=0, hold o_data, o_last and cnt stable.
REQ-026 SHALL never accept a new word while busy, except in the last-beat case of REQ-024.
REQ-027 SHALL sustain, under continuous i_valid=1 and i_ready=1, a throughput of one beat per cycle and one word every BEATS cycles.
REQ-028 SHALL ignore i_data whenever no input transfer occurs.
REQ-029 SHALL keep o_data and o_last meaningful only while o_valid=1.

Reset
REQ-030 SHALL, while rst=1 at a clock edge, set busy=0, cnt=0 and data_q=0.
REQ-031 SHALL give outputs these values after reset: o_valid=0, o_last=0, o_data=0, o_ready=1.
REQ-032 SHALL give rst priority over any simultaneous input or output transfer.
REQ-033 SHALL, on reset mid-word, discard the remaining beats with no beat emitted after reset.

Verification (DATA_WIDTH=8, BEATS=4, OPT_MSB_FIRST=0 unless stated)
REQ-034 SHALL cover basic flow: i_data=32'hDDCCBBAA accepted with i_ready=1 -> o_data is AA, BB, CC, DD on four consecutive cycles, o_last=1 only on DD, then o_valid=0.
REQ-035 SHALL cover backpressure: i_ready=0 for 3 cycles after the first beat -> o_data holds AA, o_valid=1, o_ready=0; on release the sequence continues BB, CC, DD.
REQ-036 SHALL cover back-to-back words: 32'h03020100 then 32'h07060504 with i_valid and i_ready held at 1 -> beats 00..07 on 8 consecutive cycles, o_ready=1 exactly on the 00 accept cycle and on the 03 cycle, no bubble.
REQ-037 SHALL cover MSB-first: with OPT_MSB_FIRST=1 and i_data=32'hDDCCBBAA -> beats DD, CC, BB, AA, o_last on AA.
REQ-038 SHALL cover reset mid-word: rst=1 for one cycle after beat BB -> next cycle o_valid=0, o_last=0, o_ready=1; no CC or DD beat ever appears.
REQ-039 SHALL cover last-beat stall: i_ready=0 while o_last=1 and i_valid=1 -> o_ready=0, no new word is accepted and o_data holds DD.
